// File: rtl/xor_parity_sched_pkg.sv
// xor_parity_sched shared types.
// FSM states and requester IDs.
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/xor_parity_sched_if.sv
// Requester/result handshake bundle.
// master = requesters + consumer, slave = engine.
interface xor_parity_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_parity;
  logic             res_id;
  logic             res_ready;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_parity, res_id
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_parity, res_id
  );
endinterface

// File: rtl/xor_parity_sched_exor_gate.sv
// Single two-input XOR cell.
// Shared accumulator stage of the parity engine.
module exor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/xor_parity_sched.sv
// Bit-serial parity engine, two requesters.
// Round-robin grant, one XOR cell, LSB-first.
module xor_parity_sched #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  xor_parity_sched_if.slave bus
);
  import xor_parity_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT =
    CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] gdata;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             acc_nxt;
  logic             id;
  logic             last;
  logic             gnt;
  logic             idle;
  logic             take;
  logic             rv_q;
  logic             rp_q;
  logic             ri_q;

  assign idle = (state == IDLE);

  // Grant: lone valid wins; on a tie, not-last wins.
  always_comb begin
    gnt = ID_REQ0;
    if (bus.req0_valid && bus.req1_valid)
      gnt = ~last;
    else if (bus.req1_valid)
      gnt = ID_REQ1;
  end

  assign bus.req0_ready =
    idle && bus.req0_valid && (gnt == ID_REQ0);
  assign bus.req1_ready =
    idle && bus.req1_valid && (gnt == ID_REQ1);

  assign take  = bus.req0_ready || bus.req1_ready;
  assign gdata = (gnt == ID_REQ1) ?
    bus.req1_data : bus.req0_data;

  exor_gate u_xor (
    .a (acc),
    .b (sh[0]),
    .y (acc_nxt)
  );

  assign bus.res_valid  = rv_q;
  assign bus.res_parity = rp_q;
  assign bus.res_id     = ri_q;

  // FSM, datapath and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
      id    <= ID_REQ0;
      last  <= ID_REQ1;
      rv_q  <= 1'b0;
      rp_q  <= 1'b0;
      ri_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            sh    <= gdata;
            acc   <= 1'b0;
            cnt   <= '0;
            id    <= gnt;
            last  <= gnt;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          sh  <= sh >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
            rv_q  <= 1'b1;
            rp_q  <= acc_nxt;
            ri_q  <= id;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state <= IDLE;
            rv_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/xor_parity_sched.md
# xor_parity_sched

Bit-serial parity engine that time-shares one `exor_gate` cell between two requesters. Each accepted request supplies a WIDTH-bit word. The block feeds the word LSB-first through the single XOR cell, one bit per clock, and returns the even-parity bit (XOR of all bits) tagged with the requester ID. Requesters and the result consumer connect through valid/ready handshakes. Two simultaneous requesters are served in round-robin order.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- WIDTH, default 8: data word width; legal range is WIDTH >= 1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle if valid.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle if valid.
- res_valid  output  1  result available.
- res_parity  output  1  XOR of all WIDTH bits of the accepted word.
- res_id  output  1  requester that issued the word (0 or 1).
- res_ready  input  1  consumer takes the result this cycle.

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: one bit per cycle.
  - DONE: hold the result.
- Arbitration (IDLE only):
  - The grant is combinational from req*_valid and a 1-bit `last` pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than `last` is granted.
  - reqX_ready = (state==IDLE) && grant==X. Both ready signals are 0 outside IDLE, and at most one is ever 1.
- Accept (IDLE, granted valid&ready):
  - sh <= data, acc <= 0, cnt <= 0, id <= granted index, last <= granted index.
  - state <= BUSY.
- BUSY, each cycle:
  - acc <= exor_gate(acc, sh[0]); sh >>= 1; cnt++.
  - When cnt == WIDTH-1, state <= DONE, so the block stays exactly WIDTH cycles in BUSY.
- DONE:
  - res_valid = 1; res_parity = acc; res_id = id. All are registered and stable until the handshake.
  - On res_ready, state <= IDLE.
  - No request is accepted in the same cycle as a result handshake, which leaves a one-cycle bubble in IDLE.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits.
  - Parity is 1 bit with no overflow.
  - WIDTH=1 gives one BUSY cycle.
- Outside DONE: res_valid = 0, and res_parity/res_id hold their last value (don't-care to the consumer).
- Input data is sampled only at the accept edge. Later changes to req*_data do not affect the result.

## Timing
- Reset values:
  - state=IDLE, res_valid=0, res_parity=0, res_id=0.
  - last=1, so req0 wins the first tie.
  - acc=0, cnt=0.
  - req*_ready may assert in the first cycle after rst deasserts if the matching valid is high.
- Reset mid-operation (BUSY or DONE): the transaction is aborted, nothing is reported, and all registers return to their reset values the next cycle.
- Latency: with the accept edge at edge E0, res_valid is seen high after edge E_WIDTH (WIDTH cycles after accept).
- Best-case throughput is one word per WIDTH+2 cycles: WIDTH BUSY cycles, at least one DONE cycle, and one IDLE cycle.
- Back-pressure: if res_ready stays low, the block holds DONE indefinitely and both req*_ready stay 0.
- Both requesters valid continuously: grants alternate 0,1,0,1,… starting with 0 after reset.
- A requester dropping valid before being granted is legal. Nothing is latched for it.

## Structure
- Package `xor_parity_pkg` holds:
  - the state enum (IDLE, BUSY, DONE);
  - the requester ID constants (ID_REQ0=0, ID_REQ1=1).
- The one sub-module is the existing `exor_gate` cell, instantiated once as the accumulator XOR: inputs acc and sh[0], output next-acc.
- Arbiter, counter, shifter and FSM stay inline in xor_parity_sched.

## Test plan
- Basic even result: req0_valid=1, data=8'hA5 after reset -> req0_ready=1 for one cycle; res_valid=1 eight cycles later with res_parity=0, res_id=0. Hold res_ready=1 -> back to IDLE.
- Basic odd result: req1 only, data=8'h07 -> res_parity=1, res_id=1, latency 8 cycles.
- Tie after reset: both valid, req0=8'h01, req1=8'h03 -> req0 served first (parity 1, id 0), then req1 (parity 0, id 1). Results are 10 cycles apart with res_ready held at 1.
- Sustained contention: both valid for 6 transactions -> res_id sequence 0,1,0,1,0,1, and never two ready signals in one cycle.
- Back-pressure: res_ready=0 for 20 cycles in DONE -> res_valid, res_parity and res_id stable; req*_ready=0 throughout; release -> normal resume.
- Reset and edge cases:
  - Assert rst in the 4th BUSY cycle -> next cycle state IDLE, res_valid=0, no result emitted.
  - Rerun with WIDTH=1 and data=1 -> res_parity=1 after 1 cycle.
